// File: rtl/diff_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : diff_result_checker
// Description : Compares reference/netlist result buses over a run window;
//               counts mismatches, records first failure, builds a MISR.
// Revision    : 1.0
// ============================================================================
module diff_result_checker #(
    parameter int WIDTH   = 295,
    parameter int SETTLE  = 4,
    parameter int RUN_LEN = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] y_ref,
    input  logic [WIDTH-1:0] y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      first_fail,
    output logic [31:0]      signature
);

    localparam int          c_NSLICE      = (WIDTH + 31) / 32;
    localparam int          c_PADW        = c_NSLICE * 32;
    localparam logic [15:0] c_RUN_LAST    = 16'(RUN_LEN - 1);
    localparam logic [15:0] c_SETTLE_LAST = (SETTLE > 0) ? 16'(SETTLE - 1) : 16'd0;
    localparam logic [31:0] c_POLY        = 32'h04C11DB7;
    localparam logic [15:0] c_NO_FAIL     = 16'hFFFF;
    localparam logic [31:0] c_SIG_SEED    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_mismatch_cnt;
    logic [15:0] r_first_fail;
    logic [31:0] r_signature;

    logic [c_PADW-1:0] w_pad;
    logic [31:0]       w_fold;
    logic [31:0]       w_sig_next;
    logic              w_mismatch;

    assign w_pad      = c_PADW'(y_dut);
    assign w_mismatch = (y_ref != y_dut);

    // Zero-extended bus folded into one 32-bit word, slice 0 = bits 31:0.
    always_comb begin
        w_fold = '0;
        for (int i = 0; i < c_NSLICE; i++) begin
            w_fold = w_fold ^ w_pad[i*32 +: 32];
        end
    end

    assign w_sig_next = {r_signature[30:0], 1'b0}
                      ^ (r_signature[31] ? c_POLY : 32'h0)
                      ^ w_fold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_mismatch_cnt <= '0;
            r_first_fail   <= c_NO_FAIL;
            r_signature    <= c_SIG_SEED;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state        <= (SETTLE == 0) ? S_RUN : S_SETTLE;
                        r_cnt          <= '0;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_mismatch_cnt <= '0;
                        r_first_fail   <= c_NO_FAIL;
                        r_signature    <= c_SIG_SEED;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    // Abort discards the partial run, including this cycle's sample.
                    if (abort) begin
                        r_state        <= S_IDLE;
                        r_cnt          <= '0;
                        r_busy         <= 1'b0;
                        r_mismatch_cnt <= '0;
                        r_first_fail   <= c_NO_FAIL;
                        r_signature    <= c_SIG_SEED;
                    end else begin
                        r_signature <= w_sig_next;
                        if (w_mismatch) begin
                            if (r_mismatch_cnt != 16'hFFFF) begin
                                r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
                            end
                            if (r_first_fail == c_NO_FAIL) begin
                                r_first_fail <= r_cnt;
                            end
                        end
                        if (r_cnt == c_RUN_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_done && (r_mismatch_cnt == 16'd0);
    assign mismatch_cnt = r_mismatch_cnt;
    assign first_fail   = r_first_fail;
    assign signature    = r_signature;

endmodule
`default_nettype wire

// File: tb/tb_diff_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_diff_result_checker
// Description : Directed scoreboard bench for diff_result_checker.
// Revision    : 1.0
// ============================================================================
module tb_diff_result_checker;

    localparam int c_W  = 295;
    localparam int c_SA = 4;
    localparam int c_RA = 256;

    typedef struct {
        logic [15:0] mc;
        logic [15:0] ff;
        logic [31:0] sig;
        logic        pass;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_a, abort_a, start_b, abort_b;
    logic [c_W-1:0] y_ref_a, y_dut_a, y_ref_b, y_dut_b;
    logic           busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0]    mc_a, ff_a, mc_b, ff_b;
    logic [31:0]    sig_a, sig_b;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    diff_result_checker #(.WIDTH(c_W), .SETTLE(c_SA), .RUN_LEN(c_RA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .y_ref(y_ref_a), .y_dut(y_dut_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_cnt(mc_a), .first_fail(ff_a), .signature(sig_a)
    );

    diff_result_checker #(.WIDTH(c_W), .SETTLE(0), .RUN_LEN(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .y_ref(y_ref_b), .y_dut(y_dut_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_cnt(mc_b), .first_fail(ff_b), .signature(sig_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_W-1:0] rnd_bus();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r[c_W-1:0];
    endfunction

    // Bit-serial fold: bit i lands in position i mod 32.
    function automatic logic [31:0] fold(input logic [c_W-1:0] v);
        logic [31:0] f = '0;
        for (int i = 0; i < c_W; i++) f[i % 32] = f[i % 32] ^ v[i];
        return f;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [c_W-1:0] v);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ fold(v);
    endfunction

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_mc"},   64'(mc_a),   64'd0);
        chk({tag, "_ff"},   64'(ff_a),   64'hFFFF);
        chk({tag, "_sig"},  64'(sig_a),  64'hFFFFFFFF);
    endtask

    // mode 0: equal zeros, 1: bit-294 flips at idx 10/200 and in settle,
    // 2: all cycles differ, 3: equal random data.
    task automatic run_a(input string tag, input int mode, input int abort_idx, input int start_mid);
        logic [c_W-1:0] base;
        exp_t e;
        int   busy_n = 0;
        e.mc = 16'd0; e.ff = 16'hFFFF; e.sig = 32'hFFFFFFFF;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk({tag, "_done_fall"}, 64'(done_a), 64'd0);
        if (busy_a === 1'b1) busy_n++;
        for (int s = 0; s < c_SA; s++) begin
            base    = rnd_bus();
            y_dut_a = base;
            y_ref_a = (mode == 0) ? base : ~base;
            step();
            if (busy_a === 1'b1) busy_n++;
        end
        for (int k = 0; k < c_RA; k++) begin
            base = (mode == 0) ? '0 : rnd_bus();
            y_ref_a = base;
            y_dut_a = base;
            if (mode == 1 && (k == 10 || k == 200)) y_dut_a[294] = ~base[294];
            if (mode == 2) y_ref_a = ~base;
            abort_a = (k == abort_idx);
            start_a = (k == start_mid);
            step();
            abort_a = 1'b0;
            start_a = 1'b0;
            if (k == abort_idx) begin
                chk_reset_a({tag, "_abort"});
                return;
            end
            if (y_ref_a != y_dut_a) begin
                if (e.mc != 16'hFFFF) e.mc++;
                if (e.ff == 16'hFFFF) e.ff = 16'(k);
            end
            e.sig = misr(e.sig, y_dut_a);
            if (k < c_RA - 1 && busy_a === 1'b1) busy_n++;
        end
        e.pass = (e.mc == 16'd0);
        sb.push_back(e);
        chk({tag, "_busy_end"}, 64'(busy_a), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(c_SA + c_RA));
        chk({tag, "_done"}, 64'(done_a), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_mc"},   64'(mc_a),   64'(e.mc));
            chk({tag, "_ff"},   64'(ff_a),   64'(e.ff));
            chk({tag, "_sig"},  64'(sig_a),  64'(e.sig));
            chk({tag, "_pass"}, 64'(pass_a), 64'(e.pass));
        end
    endtask

    initial begin
        logic [c_W-1:0] v;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        y_ref_a = '0; y_dut_a = '0; y_ref_b = '0; y_dut_b = '0;
        step();
        step();
        chk_reset_a("rst");
        chk("rst_pass", 64'(pass_a), 64'd0);
        rst_n = 1'b1;
        step();

        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk_reset_a("idle_abort");

        run_a("zero", 0, -1, -1);
        run_a("flip", 1, -1, -1);
        run_a("alldiff", 2, -1, -1);
        run_a("restart", 3, -1, 100);

        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("startabort_busy", 64'(busy_a), 64'd1);
        chk("startabort_done", 64'(done_a), 64'd0);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk_reset_a("settle_abort");

        run_a("abort50", 2, 50, -1);

        start_a = 1'b1;
        step();
        start_a = 1'b0;
        y_ref_a = '1;
        y_dut_a = '0;
        repeat (20) step();
        chk("async_pre_mc", 64'(mc_a), 64'd16);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_a("async");
        #1;
        rst_n = 1'b1;
        y_ref_a = '0;
        step();
        run_a("post_rst", 0, -1, -1);

        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_busy", 64'(busy_b), 64'd1);
        step();
        chk("b_done", 64'(done_b), 64'd1);
        chk("b_busy_end", 64'(busy_b), 64'd0);
        chk("b_sig_zero", 64'(sig_b), 64'hFB3EE249);
        chk("b_pass", 64'(pass_b), 64'd1);

        v = rnd_bus();
        y_dut_b = v;
        y_ref_b = v;
        y_ref_b[0] = ~v[0];
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        step();
        chk("b_sig_rnd", 64'(sig_b), 64'(misr(32'hFFFFFFFF, v)));
        chk("b_mc", 64'(mc_b), 64'd1);
        chk("b_ff", 64'(ff_b), 64'd0);
        chk("b_fail", 64'(pass_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
